// File: rtl/axo_regfile_sb_pkg.sv
// Types and index helpers shared by the scoreboarded register file
// and its read ports.
`ifndef AXO_DEFINES_SV
`include "axo_defines.sv"
`endif

package axo_regfile_sb_pkg;

  localparam int REG_IDX_W  = `AXO_REG_IDX_W;
  localparam int NREG_RV32E = `AXO_NREG_RV32E;
  localparam int NREG_RV32I = `AXO_NREG_RV32I;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  function automatic logic idx_legal(input reg_idx_t idx, input int nreg);
    return ({1'b0, idx} < (REG_IDX_W+1)'(nreg));
  endfunction

  // x0 is hardwired, so it can be neither written nor reserved
  function automatic logic idx_writable(input reg_idx_t idx, input int nreg);
    return (idx != '0) && idx_legal(idx, nreg);
  endfunction

endpackage

// File: rtl/axo_defines.sv
// Shared widths and register-count constants for the Axolotl core,
// plus a helper for slicing per-port fields out of packed port vectors.
`ifndef AXO_DEFINES_SV
`define AXO_DEFINES_SV

`define AXO_REG_IDX_W 5
`define AXO_NREG_RV32E 16
`define AXO_NREG_RV32I 32

// Part-select for field n of width w in a packed vector: vec[`AXO_RD_SLICE(n, w)]
`define AXO_RD_SLICE(n, w) ((w)*(n)) +: (w)

`endif

// File: rtl/axo_regfile_rdport.sv
// One combinational read port: index decode, legality, optional write
// bypass and busy override for a same-cycle release/reserve.
module axo_regfile_rdport
  import axo_regfile_sb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic                 rst,
  input  reg_idx_t             idx,
  input  logic [NREG*XLEN-1:0] file_flat,
  input  logic [NREG-1:0]      busy_vec,
  input  logic                 we,
  input  reg_idx_t             rd,
  input  logic [XLEN-1:0]      din,
  input  logic                 rsv_ok,
  input  reg_idx_t             rsv_idx,
  output logic [XLEN-1:0]      data,
  output logic                 busy,
  output logic                 illegal
);

  logic [XLEN-1:0] raw_data;
  logic            raw_busy;
  logic            hit_bypass;

  always_comb begin
    raw_data = '0;
    raw_busy = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == REG_IDX_W'(i)) begin
        raw_data = file_flat[XLEN*i +: XLEN];
        raw_busy = busy_vec[i];
      end
    end

    illegal    = !idx_legal(idx, NREG);
    hit_bypass = (BYPASS != 0) && we && !rst && (rd == idx);

    data = raw_data;
    busy = raw_busy;
    if ((idx == '0) || illegal) begin
      data = '0;
      busy = 1'b0;
    end else if (hit_bypass) begin
      // A releasing write clears busy unless the same register is re-reserved
      data = din;
      busy = rsv_ok && (rsv_idx == idx);
    end
  end

endmodule

// File: rtl/axo_regfile_sb.sv
// Parametrised integer register file with a per-register busy scoreboard:
// issue reserves destinations, writeback releases them, flush squashes all.
`ifndef AXO_DEFINES_SV
`include "axo_defines.sv"
`endif

module axo_regfile_sb
  import axo_regfile_sb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD*REG_IDX_W-1:0] rs_idx,
  output logic [NRD*XLEN-1:0]      rs_data,
  output logic [NRD-1:0]           rs_busy,
  output logic [NRD-1:0]           rs_illegal,
  input  logic                     we,
  input  reg_idx_t                 rd,
  input  logic [XLEN-1:0]          din,
  input  logic                     rsv_en,
  input  reg_idx_t                 rsv_idx,
  output logic                     rsv_ok,
  input  logic                     flush
);

  logic [XLEN-1:0]      regs [NREG];
  logic [NREG-1:0]      busy;
  logic [NREG-1:0]      busy_nxt;
  logic [NREG*XLEN-1:0] file_flat;
  logic                 wr_ok;
  logic                 rsv_tgt_busy;

  assign wr_ok = we && idx_writable(rd, NREG);

  always_comb begin
    rsv_tgt_busy = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (rsv_idx == REG_IDX_W'(i)) rsv_tgt_busy = busy[i];
    end
  end

  // A busy target is only grantable when writeback releases it this very cycle
  assign rsv_ok = rsv_en && !rst && !flush && idx_writable(rsv_idx, NREG) &&
                  (!rsv_tgt_busy || (we && (rd == rsv_idx)));

  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NREG; i++) begin
      if (wr_ok && (rd == REG_IDX_W'(i))) busy_nxt[i] = 1'b0;
    end
    if (flush) busy_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rsv_ok && (rsv_idx == REG_IDX_W'(i))) busy_nxt[i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_ok && (rd == REG_IDX_W'(i))) regs[i] <= din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_comb begin
    file_flat = '0;
    for (int i = 0; i < NREG; i++) file_flat[XLEN*i +: XLEN] = regs[i];
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rdport
    axo_regfile_rdport #(
      .XLEN   (XLEN),
      .NREG   (NREG),
      .BYPASS (BYPASS)
    ) u_rdport (
      .rst       (rst),
      .idx       (rs_idx[`AXO_RD_SLICE(g, REG_IDX_W)]),
      .file_flat (file_flat),
      .busy_vec  (busy),
      .we        (we),
      .rd        (rd),
      .din       (din),
      .rsv_ok    (rsv_ok),
      .rsv_idx   (rsv_idx),
      .data      (rs_data[`AXO_RD_SLICE(g, XLEN)]),
      .busy      (rs_busy[g]),
      .illegal   (rs_illegal[g])
    );
  end

endmodule
